uart_sram_bridge: RTL
=====================

// Module: uart_sram_bridge
// PURPOSE
// Byte-stream command engine between a UART RX/TX pair and an external async SRAM.
// Parses framed host commands (write, read, fill, ping) with parametrised address/length width.
// Drives SRAM strobes and streams read data to the TX byte interface.
// Adds inter-byte timeout recovery. Successor to the fixed 19-bit / 8-bit-length UART SRAM controller.
// PARAMETERS
// AW          19     SRAM address width, 1..32; address field is ceil(AW/8) bytes, MSB first
// LW          16     burst length width, 8 or 16; length field is LW/8 bytes, MSB first
// RD_LAT      2      cycles from sram_oe assert to sram_din valid, 1..7
// TIMEOUT_CYC 30000  idle clk cycles between RX bytes before abort to IDLE; 0 disables
// PORTS
// clk        in   1   system clock
// reset      in   1   asynchronous active-low reset
// rx_dat     in   8   received byte from UART RX
// rx_stb     in   1   1-cycle pulse, rx_dat valid
// tx_dat     out  8   byte to UART TX
// tx_start   out  1   1-cycle pulse, load tx_dat
// tx_busy    in   1   TX shifting; rises the cycle after tx_start
// sram_addr  out  AW  SRAM address
// sram_dout  out  8   SRAM write data
// sram_din   in   8   SRAM read data
// sram_we    out  1   write strobe, 1-cycle pulse
// sram_oe    out  1   output enable, held for RD_LAT cycles per read
// busy       out  1   high whenever state != IDLE
// BEHAVIOUR
// - Reset (reset=0, async): state IDLE; all outputs 0; addr, len, timeout and checksum registers 0.
// - Frame: CMD, ADDR[ceil(AW/8) bytes], LEN[LW/8 bytes], then payload. Excess ADDR high bits dropped.
// - CMD 0x57 'W': LEN payload bytes; each byte -> sram_dout, sram_we pulse the cycle after rx_stb, addr+1.
// - CMD 0x52 'R': LEN reads: sram_oe high RD_LAT cycles, capture sram_din, addr+1, send byte on TX.
// - CMD 0x46 'F': one payload byte; written to LEN consecutive addresses, one sram_we per 2 cycles.
// - CMD 0x50 'P': no ADDR/LEN fields; replies 0x53. Any other CMD ignored, stays IDLE.
// - W and F end by sending ack 0x4B; R ends after last data byte (plus checksum, see CONFIGURATION).
// - LEN=0: no SRAM access; W/F send ack at once (F still consumes its fill byte); R sends nothing.
// - Address increments modulo 2^AW; wrap from all-ones to 0 is legal and silent.
// - States: IDLE, ADDR, LEN, WDATA, FDATA, FILL, RD_OE, TX_GO, TX_WAIT, ACK.
// - TX handshake: tx_start pulses only when tx_busy=0; skip one cycle, then wait for tx_busy=0.
// - Next SRAM read starts only after the previous byte's tx_busy falls; no read-ahead.
// - Timeout: counter clears on rx_stb, runs in ADDR/LEN/WDATA/FDATA; at TIMEOUT_CYC -> IDLE, no ack.
// - rx_stb during R, FILL or TX states is dropped; the host must wait for the response.
// - sram_we and sram_oe never both high; sram_addr stable while either is high.
// CONFIGURATION
// UART_SRAM_CSUM_EN defined: running 8-bit sum (mod 256) of every payload byte written (W) or read (R).
//   W: the ack is followed by the sum byte. R: the sum byte is sent after the last data byte.
//   F: no sum. Sum clears at each CMD byte.
// Undefined: no checksum logic; responses are exactly as described in BEHAVIOUR.
// TESTING
// - Ping: rx 0x50 -> tx exactly one byte 0x53; busy returns low.
// - W AW=19: 57 00 01 00 00 03 AA BB CC -> we at 0x00100/101/102 with AA/BB/CC; tx 4B (+ 31 w/ CSUM).
// - R same region, LEN=3, RD_LAT=2 -> oe 2 cycles each; tx AA BB CC (+31 w/ CSUM); no tx_start while busy.
// - F wrap: 46 07 FF FF 00 02 5A -> writes 5A to 0x7FFFF then 0x00000; tx 4B.
// - Timeout: 57 00 01 then silence TIMEOUT_CYC cycles -> IDLE, no tx; next 50 answered with 53.
// - Async reset asserted mid-R burst -> all outputs 0 at once; post-reset ping answered normally.

Source files
------------

// File: rtl/uart_sram_bridge.sv
// rtl/uart_sram_bridge.sv - UART byte-stream command engine driving an async SRAM
//
// Host frames: CMD, ADDR (ceil(AW/8) bytes, MSB first), LEN (LW/8 bytes, MSB first), payload.
//   0x57 'W' write LEN bytes, ack 0x4B
//   0x52 'R' read LEN bytes, each returned on TX
//   0x46 'F' fill LEN addresses with one payload byte, ack 0x4B
//   0x50 'P' ping (no fields), reply 0x53
// Optional feature macro: UART_SRAM_CSUM_EN appends a mod-256 payload sum to W and R responses.
//
// Ports:
//   clk        system clock
//   reset      asynchronous active-low reset
//   rx_dat     received byte, valid with rx_stb (1-cycle pulse)
//   tx_dat     byte to transmit, loaded by tx_start (1-cycle pulse)
//   tx_busy    transmitter shifting; rises the cycle after tx_start
//   sram_addr  SRAM address (AW bits)
//   sram_dout  SRAM write data
//   sram_din   SRAM read data, valid RD_LAT cycles after sram_oe rises
//   sram_we    SRAM write strobe, 1-cycle pulse
//   sram_oe    SRAM output enable, held RD_LAT cycles per read
//   busy       high whenever the engine is not idle
module uart_sram_bridge #(
    parameter int AW          = 19,
    parameter int LW          = 16,
    parameter int RD_LAT      = 2,
    parameter int TIMEOUT_CYC = 30000
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [7:0]    rx_dat,
    input  logic          rx_stb,
    output logic [7:0]    tx_dat,
    output logic          tx_start,
    input  logic          tx_busy,
    output logic [AW-1:0] sram_addr,
    output logic [7:0]    sram_dout,
    input  logic [7:0]    sram_din,
    output logic          sram_we,
    output logic          sram_oe,
    output logic          busy
);

    localparam int AB = (AW + 7) / 8;
    localparam int LB = LW / 8;

    localparam logic [7:0] CMD_W    = 8'h57;
    localparam logic [7:0] CMD_R    = 8'h52;
    localparam logic [7:0] CMD_F    = 8'h46;
    localparam logic [7:0] CMD_P    = 8'h50;
    localparam logic [7:0] RSP_PING = 8'h53;
    localparam logic [7:0] RSP_ACK  = 8'h4B;

`ifdef UART_SRAM_CSUM_EN
    localparam bit CSUM_EN = 1'b1;
    logic [7:0] csum;
`else
    localparam bit CSUM_EN = 1'b0;
`endif

    typedef enum logic [3:0] {
        S_IDLE, S_ADDR, S_LEN, S_WDATA, S_FDATA, S_FILL,
        S_RD_OE, S_TX_GO, S_TX_WAIT, S_ACK
    } state_t;

    state_t        state, state_nxt;
    logic [7:0]    cmd;
    logic [AW-1:0] addr;
    logic [LW-1:0] len;
    logic [LW-1:0] len_new;
    logic [2:0]    cnt;
    logic [2:0]    oe_cnt;
    logic [31:0]   tmo;
    logic [7:0]    tx_byte;
    logic [7:0]    dout;
    logic          we_r;
    logic          tail;   // byte in flight is the last of the response
    logic          skip;   // ignore tx_busy on the first TX_WAIT cycle
    logic          in_rx;
    logic          tmo_hit;
    logic          rd_done;
    logic          tx_done;
    logic          more_rd;

    assign len_new  = (len << 8) | LW'(rx_dat);
    assign in_rx    = (state == S_ADDR) || (state == S_LEN) ||
                      (state == S_WDATA) || (state == S_FDATA);
    assign tmo_hit  = (TIMEOUT_CYC != 0) && !rx_stb && (tmo == 32'(TIMEOUT_CYC - 1));
    assign rd_done  = (state == S_RD_OE) && (oe_cnt == 3'(RD_LAT - 1));
    assign tx_done  = (state == S_TX_WAIT) && !skip && !tx_busy;
    assign more_rd  = (cmd == CMD_R) && (len != '0);

    assign tx_dat    = tx_byte;
    assign tx_start  = (state == S_TX_GO) && !tx_busy;
    assign sram_addr = addr;
    assign sram_dout = dout;
    assign sram_we   = we_r;
    assign sram_oe   = (state == S_RD_OE);
    assign busy      = (state != S_IDLE);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= S_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (rx_stb) begin
                    if (rx_dat == CMD_P)
                        state_nxt = S_TX_GO;
                    else if (rx_dat == CMD_W || rx_dat == CMD_R || rx_dat == CMD_F)
                        state_nxt = S_ADDR;
                end
            end
            S_ADDR: if (rx_stb && cnt == 3'(AB - 1)) state_nxt = S_LEN;
            S_LEN: begin
                if (rx_stb && cnt == 3'(LB - 1)) begin
                    if (cmd == CMD_W)      state_nxt = (len_new == '0) ? S_ACK  : S_WDATA;
                    else if (cmd == CMD_R) state_nxt = (len_new == '0) ? S_IDLE : S_RD_OE;
                    else                   state_nxt = S_FDATA;
                end
            end
            S_WDATA:   if (rx_stb && len == LW'(1)) state_nxt = S_ACK;
            S_FDATA:   if (rx_stb) state_nxt = (len == '0) ? S_ACK : S_FILL;
            S_FILL:    if (!we_r && len == '0) state_nxt = S_ACK;
            S_RD_OE:   if (rd_done) state_nxt = S_TX_GO;
            S_TX_GO:   if (!tx_busy) state_nxt = S_TX_WAIT;
            S_TX_WAIT: begin
                if (tx_done) begin
                    if (tail)         state_nxt = S_IDLE;
                    else if (more_rd) state_nxt = S_RD_OE;
                    else              state_nxt = S_TX_GO;   // checksum byte follows
                end
            end
            S_ACK:     state_nxt = S_TX_GO;
            default:   state_nxt = S_IDLE;
        endcase
        if (in_rx && tmo_hit) state_nxt = S_IDLE;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cmd     <= '0;
            addr    <= '0;
            len     <= '0;
            cnt     <= '0;
            oe_cnt  <= '0;
            tmo     <= '0;
            tx_byte <= '0;
            dout    <= '0;
            we_r    <= 1'b0;
            tail    <= 1'b0;
            skip    <= 1'b0;
        end else begin
            we_r <= 1'b0;
            // Advance the address the cycle after each write so it is stable under sram_we.
            if (we_r) addr <= addr + AW'(1);
            if (in_rx && !rx_stb) tmo <= tmo + 32'd1;
            else                  tmo <= '0;

            case (state)
                S_IDLE: begin
                    if (rx_stb) begin
                        cmd  <= rx_dat;
                        cnt  <= '0;
                        addr <= '0;
                        len  <= '0;
                        if (rx_dat == CMD_P) begin
                            tx_byte <= RSP_PING;
                            tail    <= 1'b1;
                        end
                    end
                end
                S_ADDR: begin
                    if (rx_stb) begin
                        addr <= (addr << 8) | AW'(rx_dat);
                        cnt  <= (cnt == 3'(AB - 1)) ? 3'd0 : cnt + 3'd1;
                    end
                end
                S_LEN: begin
                    if (rx_stb) begin
                        len <= len_new;
                        cnt <= cnt + 3'd1;
                    end
                end
                S_WDATA: begin
                    if (rx_stb) begin
                        dout <= rx_dat;
                        we_r <= 1'b1;
                        len  <= len - LW'(1);
                    end
                end
                S_FDATA: if (rx_stb) dout <= rx_dat;
                S_FILL: begin
                    // Alternate strobe / address-advance cycles.
                    if (!we_r && len != '0) begin
                        we_r <= 1'b1;
                        len  <= len - LW'(1);
                    end
                end
                S_RD_OE: begin
                    if (rd_done) begin
                        oe_cnt  <= '0;
                        tx_byte <= sram_din;
                        addr    <= addr + AW'(1);
                        len     <= len - LW'(1);
                        tail    <= (len == LW'(1)) && !CSUM_EN;
                    end else begin
                        oe_cnt <= oe_cnt + 3'd1;
                    end
                end
                S_TX_GO: if (!tx_busy) skip <= 1'b1;
                S_TX_WAIT: begin
                    if (skip) begin
                        skip <= 1'b0;
                    end else if (tx_done && !tail && !more_rd) begin
`ifdef UART_SRAM_CSUM_EN
                        tx_byte <= csum;
`endif
                        tail <= 1'b1;
                    end
                end
                S_ACK: begin
                    tx_byte <= RSP_ACK;
                    tail    <= !(CSUM_EN && cmd == CMD_W);
                end
                default: ;
            endcase
        end
    end

`ifdef UART_SRAM_CSUM_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)                         csum <= '0;
        else if (state == S_IDLE && rx_stb) csum <= '0;
        else if (state == S_WDATA && rx_stb) csum <= csum + rx_dat;
        else if (rd_done)                   csum <= csum + sram_din;
    end
`endif

endmodule
